// File: rtl/jtframe_inputs.sv
// Player-input front end: merges PS/2 key events and MiSTer joystick words into
// registered active-low per-player buses, with coin stretching, autofire and pause.
module jtframe_inputs #(
  parameter int PLAYERS   = 2,
  parameter int BUTTONS   = 2,
  parameter int JOY_SHARE = 1,
  parameter int COIN_LEN  = 4,
  parameter int AF_PERIOD = 3
) (
  input  logic                            clk_sys,
  input  logic                            rst_n,
  input  logic                            cen,
  input  logic [10:0]                     ps2_key,
  input  logic [16*PLAYERS-1:0]           joy,
  input  logic [BUTTONS-1:0]              af_en,
  input  logic                            pause_clr,
  output logic [(4+BUTTONS)*PLAYERS-1:0]  joy_n,
  output logic [PLAYERS-1:0]              start_n,
  output logic [PLAYERS-1:0]              coin_n,
  output logic                            pause
);
  localparam int JW = 4 + BUTTONS;
  localparam int CW = $clog2(COIN_LEN + 1);
  localparam int AW = $clog2(AF_PERIOD + 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_LEN);
  localparam logic [AW-1:0] AF_LAST   = AW'(AF_PERIOD - 1);

  // kb_q map: 0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2,
  // 6 start1, 7 start2, 8 coin1, 9 coin2, 10 pause
  logic                 tog_q, tog_d;
  logic [10:0]          kb_q, kb_d;
  logic [PLAYERS-1:0]   coin_prev_q, coin_prev_d;
  logic [CW-1:0]        coin_cnt_q [PLAYERS];
  logic [CW-1:0]        coin_cnt_d [PLAYERS];
  logic [AW-1:0]        af_cnt_q [PLAYERS][BUTTONS];
  logic [AW-1:0]        af_cnt_d [PLAYERS][BUTTONS];
  logic [BUTTONS-1:0]   af_ph_q [PLAYERS];
  logic [BUTTONS-1:0]   af_ph_d [PLAYERS];
  logic [BUTTONS-1:0]   af_held_q [PLAYERS];
  logic [BUTTONS-1:0]   af_held_d [PLAYERS];
  logic                 pause_prev_q, pause_prev_d;
  logic                 pause_q, pause_d;
  logic [JW*PLAYERS-1:0] joy_n_q, joy_n_d;
  logic [PLAYERS-1:0]   start_n_q, start_n_d;
  logic [PLAYERS-1:0]   coin_n_q, coin_n_d;

  logic [15:0]          jor, jsel;
  logic [BUTTONS-1:0]   kb_btn, btn_out;
  logic [3:0]           kb_start, kb_coin;
  logic [3:0]           src_dir [PLAYERS];
  logic [BUTTONS-1:0]   src_btn [PLAYERS];
  logic [PLAYERS-1:0]   src_start, src_coin;
  logic                 src_pause, af_act;
  logic                 unused_bits;

  assign unused_bits = ^{ps2_key[8], jor, jsel, kb_q};

  always_comb begin
    tog_d = ps2_key[10];
    kb_d  = kb_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[7:0])
        8'h74:        kb_d[0]  = ps2_key[9];
        8'h6B:        kb_d[1]  = ps2_key[9];
        8'h72:        kb_d[2]  = ps2_key[9];
        8'h75:        kb_d[3]  = ps2_key[9];
        8'h14, 8'h11: kb_d[4]  = ps2_key[9];
        8'h29:        kb_d[5]  = ps2_key[9];
        8'h05:        kb_d[6]  = ps2_key[9];
        8'h06:        kb_d[7]  = ps2_key[9];
        8'h04:        kb_d[8]  = ps2_key[9];
        8'h03:        kb_d[9]  = ps2_key[9];
        8'h0C:        kb_d[10] = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Per-player source: keyboard latch OR the selected joystick word
  always_comb begin
    jor = '0;
    for (int p = 0; p < PLAYERS; p++) jor = jor | joy[16*p +: 16];
    kb_btn = '0;
    for (int b = 0; b < BUTTONS && b < 2; b++) kb_btn[b] = kb_q[4+b];
    kb_start  = {2'b00, kb_q[7:6]};
    kb_coin   = {2'b00, kb_q[9:8]};
    src_pause = kb_q[10] | jor[6+BUTTONS];
    jsel      = '0;
    src_start = '0;
    src_coin  = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      jsel         = (JOY_SHARE != 0) ? jor : joy[16*p +: 16];
      src_dir[p]   = jsel[3:0] | ((p == 0) ? kb_q[3:0] : 4'b0000);
      src_btn[p]   = jsel[4 +: BUTTONS] | ((p == 0) ? kb_btn : {BUTTONS{1'b0}});
      src_start[p] = jsel[4+BUTTONS] | kb_start[p];
      src_coin[p]  = jsel[5+BUTTONS] | kb_coin[p];
    end
  end

  always_comb begin
    joy_n_d     = '1;
    start_n_d   = '1;
    coin_n_d    = '1;
    coin_prev_d = src_coin;
    btn_out     = '0;
    af_act      = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      // An edge only arms the counter while it is idle, so a held coin pulses once
      coin_cnt_d[p] = coin_cnt_q[p];
      if (coin_cnt_q[p] == '0) begin
        if (src_coin[p] && !coin_prev_q[p]) coin_cnt_d[p] = COIN_LOAD;
      end else if (cen) begin
        coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
      end
      coin_n_d[p]  = (coin_cnt_d[p] == '0);
      start_n_d[p] = ~src_start[p];
      af_ph_d[p]   = af_ph_q[p];
      af_held_d[p] = af_held_q[p];
      for (int b = 0; b < BUTTONS; b++) begin
        af_act         = src_btn[p][b] & af_en[b];
        af_cnt_d[p][b] = af_cnt_q[p][b];
        if (!af_act) begin
          af_cnt_d[p][b] = '0;
          af_ph_d[p][b]  = 1'b0;
        end else if (af_held_q[p][b] && cen) begin
          if (af_cnt_q[p][b] == AF_LAST) begin
            af_cnt_d[p][b] = '0;
            af_ph_d[p][b]  = ~af_ph_q[p][b];
          end else begin
            af_cnt_d[p][b] = af_cnt_q[p][b] + AW'(1);
          end
        end
        af_held_d[p][b] = af_act;
        btn_out[b]      = src_btn[p][b] & ~(af_en[b] & af_ph_d[p][b]);
      end
      joy_n_d[JW*p +: JW] = ~{btn_out, src_dir[p]};
    end
    pause_prev_d = src_pause;
    pause_d      = pause_q;
    if (pause_clr) pause_d = 1'b0;
    else if (src_pause && !pause_prev_q) pause_d = ~pause_q;
  end

  // Edge registers reset high: a source held through reset must be seen low first
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tog_q        <= 1'b0;
      kb_q         <= '0;
      coin_prev_q  <= '1;
      pause_prev_q <= 1'b1;
      pause_q      <= 1'b0;
      joy_n_q      <= '1;
      start_n_q    <= '1;
      coin_n_q     <= '1;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_cnt_q[p] <= '0;
        af_ph_q[p]    <= '0;
        af_held_q[p]  <= '0;
        for (int b = 0; b < BUTTONS; b++) af_cnt_q[p][b] <= '0;
      end
    end else begin
      tog_q        <= tog_d;
      kb_q         <= kb_d;
      coin_prev_q  <= coin_prev_d;
      pause_prev_q <= pause_prev_d;
      pause_q      <= pause_d;
      joy_n_q      <= joy_n_d;
      start_n_q    <= start_n_d;
      coin_n_q     <= coin_n_d;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_cnt_q[p] <= coin_cnt_d[p];
        af_ph_q[p]    <= af_ph_d[p];
        af_held_q[p]  <= af_held_d[p];
        for (int b = 0; b < BUTTONS; b++) af_cnt_q[p][b] <= af_cnt_d[p][b];
      end
    end
  end

  assign joy_n   = joy_n_q;
  assign start_n = start_n_q;
  assign coin_n  = coin_n_q;
  assign pause   = pause_q;

endmodule

// File: tb/tb_jtframe_inputs.sv
// Directed bench for jtframe_inputs (2 players, 2 buttons, separate joysticks,
// COIN_LEN=4, AF_PERIOD=3); cen is a 1-in-4 tick generated by the bench.
module tb_jtframe_inputs;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic [1:0]  af_en;
  logic        pause_clr;
  logic [11:0] joy_n;
  logic [1:0]  start_n;
  logic [1:0]  coin_n;
  logic        pause;

  int          n_vec = 0;
  int          n_err = 0;
  logic        tog = 1'b0;
  logic        cen_run = 1'b0;
  logic [1:0]  div = 2'd0;
  logic [0:0]  exp_q[$];

  typedef struct {
    logic [31:0] joy;
    logic [11:0] exp_joy_n;
    logic [1:0]  exp_start_n;
  } vec_t;
  vec_t tbl[9];

  jtframe_inputs #(
    .PLAYERS(2), .BUTTONS(2), .JOY_SHARE(0), .COIN_LEN(4), .AF_PERIOD(3)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cen(cen), .ps2_key(ps2_key), .joy(joy),
    .af_en(af_en), .pause_clr(pause_clr), .joy_n(joy_n), .start_n(start_n),
    .coin_n(coin_n), .pause(pause)
  );

  // clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    cen = cen_run && (div == 2'd0);
    div = div + 2'd1;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic key(input logic [7:0] code, input logic pressed);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  initial begin
    int falls, low_cens, p1_low, cens, lows;
    logic prev;

    tbl[0] = '{32'h0000_0000, 12'hFFF, 2'b11};
    tbl[1] = '{32'h0000_0008, 12'hFF7, 2'b11};
    tbl[2] = '{32'h0000_0011, 12'hFEE, 2'b11};
    tbl[3] = '{32'h0022_0000, 12'h77F, 2'b11};
    tbl[4] = '{32'h0000_0040, 12'hFFF, 2'b10};
    tbl[5] = '{32'h0040_0000, 12'hFFF, 2'b01};
    tbl[6] = '{32'h003F_003F, 12'h000, 2'b11};
    tbl[7] = '{32'h0008_0004, 12'hDFB, 2'b11};
    tbl[8] = '{32'h0020_0010, 12'h7EF, 2'b11};

    rst_n = 1'b0; cen = 1'b0; ps2_key = '0; joy = '0; af_en = '0; pause_clr = 1'b0;
    cycn(2);
    chk("rst_joy_n", 32'(joy_n), 32'hFFF);
    chk("rst_start_n", 32'(start_n), 32'h3);
    chk("rst_coin_n", 32'(coin_n), 32'h3);
    chk("rst_pause", 32'(pause), 32'h0);
    rst_n = 1'b1;
    cyc();

    // joystick vectors, one clock latency
    for (int i = 0; i < 9; i++) begin
      joy = tbl[i].joy;
      cyc();
      chk($sformatf("tbl%0d_joy_n", i), 32'(joy_n), 32'(tbl[i].exp_joy_n));
      chk($sformatf("tbl%0d_start_n", i), 32'(start_n), 32'(tbl[i].exp_start_n));
    end
    joy = '0;
    cyc();

    // keyboard: two clock latency
    key(8'h14, 1'b1); cyc();
    chk("kb_fire1_lat1", 32'(joy_n), 32'hFFF);
    cyc();
    chk("kb_fire1_on", 32'(joy_n), 32'hFEF);
    key(8'h14, 1'b0); cycn(2);
    chk("kb_fire1_off", 32'(joy_n), 32'hFFF);
    key(8'h11, 1'b1); cycn(2);
    chk("kb_fire1_alt_on", 32'(joy_n), 32'hFEF);
    key(8'h11, 1'b0); cycn(2);
    chk("kb_fire1_alt_off", 32'(joy_n), 32'hFFF);
    key(8'h75, 1'b1); cycn(2);
    chk("kb_up_on", 32'(joy_n), 32'hFF7);
    key(8'h75, 1'b0); cycn(2);
    key(8'h29, 1'b1); cycn(2);
    chk("kb_fire2_on", 32'(joy_n), 32'hFDF);
    key(8'h29, 1'b0); cycn(2);
    key(8'h06, 1'b1); cycn(2);
    chk("kb_start2_on", 32'(start_n), 32'h1);
    key(8'h06, 1'b0); cycn(2);
    chk("kb_start2_off", 32'(start_n), 32'h3);
    key(8'h1C, 1'b1); cycn(2);
    chk("kb_unknown_code", 32'(joy_n), 32'hFFF);
    key(8'h1C, 1'b0); cycn(2);
    ps2_key = {tog, 1'b1, 1'b0, 8'h14}; cycn(2);
    chk("kb_no_toggle", 32'(joy_n), 32'hFFF);

    // keyboard and joystick overlap: releasing one must not glitch
    key(8'h14, 1'b1); cycn(2);
    joy = 32'h10; cyc();
    key(8'h14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("overlap_hold%0d", i), 32'(joy_n), 32'hFEF);
    end
    joy = '0; cyc();
    chk("overlap_release", 32'(joy_n), 32'hFFF);

    // coin stretch: one pulse of 4 cen ticks, re-press inside window ignored
    cen_run = 1'b1;
    joy = 32'h80;
    falls = 0; low_cens = 0; p1_low = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 6) joy = 32'h0;
      if (i == 8) joy = 32'h80;
      prev = coin_n[0];
      cyc();
      if (i == 0) chk("coin_lat", 32'(coin_n[0]), 32'h0);
      if (!prev && cen) low_cens++;
      if (prev && !coin_n[0]) falls++;
      if (!coin_n[1]) p1_low++;
    end
    chk("coin_pulses", 32'(falls), 32'd1);
    chk("coin_low_cens", 32'(low_cens), 32'd4);
    chk("coin_p1_idle", 32'(p1_low), 32'd0);
    joy = '0; cyc();
    chk("coin_idle", 32'(coin_n), 32'h3);

    cen_run = 1'b0;
    key(8'h03, 1'b1); cycn(2);
    chk("kb_coin2_on", 32'(coin_n), 32'h1);
    key(8'h03, 1'b0);
    cen_run = 1'b1; cycn(20);
    chk("kb_coin2_done", 32'(coin_n), 32'h3);

    // autofire on fire1, plain fire2 held alongside
    af_en = 2'b01;
    while (div != 2'd1) cyc();
    joy = 32'h30;
    cens = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (i > 0 && cen) cens++;
      exp_q.push_back(((cens / 3) % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("af_fire1_c%0d", i), 32'(joy_n[4]), 32'(exp_q.pop_front()));
      if (i % 8 == 0) chk($sformatf("af_fire2_c%0d", i), 32'(joy_n[5]), 32'h0);
    end
    joy = '0; cyc();
    chk("af_release", 32'(joy_n), 32'hFFF);
    while (div != 2'd1) cyc();
    joy = 32'h10;
    cyc();
    chk("af_repress", 32'(joy_n[4]), 32'h0);
    while (joy_n[4] == 1'b0 && cens < 200) begin cyc(); cens++; end
    chk("af_went_high", 32'(joy_n[4]), 32'h1);
    af_en = 2'b00; cyc();
    chk("af_disable", 32'(joy_n[4]), 32'h0);
    joy = '0; cen_run = 1'b0; cyc();

    // pause toggle and clear
    key(8'h0C, 1'b1); cycn(3);
    chk("pause_kb_1", 32'(pause), 32'h1);
    key(8'h0C, 1'b0); cycn(3);
    chk("pause_kb_rel", 32'(pause), 32'h1);
    key(8'h0C, 1'b1); cycn(3);
    chk("pause_kb_2", 32'(pause), 32'h0);
    key(8'h0C, 1'b0); cycn(3);
    joy = 32'h0100_0000; cyc();
    chk("pause_joy1", 32'(pause), 32'h1);
    joy = '0; cyc();
    joy = 32'h100; pause_clr = 1'b1; cyc();
    chk("pause_clr_from1", 32'(pause), 32'h0);
    pause_clr = 1'b0; joy = '0; cyc();
    joy = 32'h100; pause_clr = 1'b1; cyc();
    chk("pause_clr_from0", 32'(pause), 32'h0);
    pause_clr = 1'b0; joy = '0; cyc();

    // reset during a coin pulse with the coin still held
    key(8'h0C, 1'b1); cycn(3);
    key(8'h0C, 1'b0); cycn(3);
    cen_run = 1'b1;
    joy = 32'h80; cycn(3);
    chk("rst_mid_coin_low", 32'(coin_n[0]), 32'h0);
    rst_n = 1'b0; ps2_key = '0; tog = 1'b0;
    #1;
    chk("rst_mid_coin_n", 32'(coin_n), 32'h3);
    chk("rst_mid_pause", 32'(pause), 32'h0);
    cyc();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (!coin_n[0]) lows++;
    end
    chk("post_rst_held_coin", 32'(lows), 32'd0);
    joy = '0; cycn(2);
    joy = 32'h80; cyc();
    chk("post_rst_repress", 32'(coin_n[0]), 32'h0);
    joy = '0; cycn(20);
    chk("post_rst_done", 32'(coin_n), 32'h3);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
